// File: rtl/rf_pkg.sv
// Shared constants and types for the register file with busy scoreboard.
// Default widths match the classic 32x32 file that this block replaces.
package rf_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_RD_MAX = 4;

    typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
    typedef logic [DATA_W_DEF-1:0] rf_data_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking. Issue sets a bit and writeback clears it.
// busy_cnt_o is the registered popcount of the vector after the update.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_vld_i,
    input  logic [ADDR_W-1:0]        set_addr_i,
    input  logic                     clr_vld_i,
    input  logic [ADDR_W-1:0]        clr_addr_i,
    output logic [(1<<ADDR_W)-1:0]   busy_o,
    output logic [ADDR_W:0]          busy_cnt_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;

    function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // The set is applied after the clear so a new producer supersedes the retiring one.
    always_comb begin
        busy_d = busy_q;
        if (clr_vld_i) begin
            busy_d[clr_addr_i] = 1'b0;
        end
        if (set_vld_i) begin
            busy_d[set_addr_i] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[0] = 1'b0;
        end
        cnt_d = popcount(busy_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file: NUM_RD combinational read ports, one write port, optional
// hardwired zero register, write-to-read bypass and a RAW busy scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RW,
    input  logic [ADDR_W-1:0]        DA,
    input  logic [DATA_W-1:0]        D_DATA,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_en,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     issue_vld,
    input  logic [ADDR_W-1:0]        issue_dst,
    output logic                     stall,
    output logic [ADDR_W:0]          busy_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy_vec;
    logic              wr_en;

    assign wr_en = RW && !((ZERO_REG != 0) && (DA == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[DA] <= D_DATA;
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (issue_vld),
        .set_addr_i (issue_dst),
        .clr_vld_i  (RW),
        .clr_addr_i (DA),
        .busy_o     (busy_vec),
        .busy_cnt_o (busy_cnt)
    );

    // Read outputs are forced low during reset so an in-flight write cannot bypass through.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[k*ADDR_W +: ADDR_W];
        assign hit  = (BYPASS != 0) && RW && (DA == addr);

        always_comb begin
            data = regs_q[addr];
            if (hit) begin
                data = D_DATA;
            end
            if (((ZERO_REG != 0) && (addr == '0)) || rst) begin
                data = '0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = data;
        assign rd_busy[k] = !rst && busy_vec[addr] && !hit;
    end

    assign stall = |(rd_en & rd_busy);
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: reset, fill, vector table, hazard corner cases and a
// randomized run against an array-based reference model; one DUT per BYPASS setting.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        RW;
    logic [4:0]  DA;
    logic [31:0] D_DATA;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_en;
    logic        issue_vld;
    logic [4:0]  issue_dst;

    logic [63:0] rd_data, rd_data_nb;
    logic [1:0]  rd_busy, rd_busy_nb;
    logic        stall, stall_nb;
    logic [5:0]  busy_cnt, busy_cnt_nb;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .RW(RW), .DA(DA), .D_DATA(D_DATA),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .rd_busy(rd_busy),
        .issue_vld(issue_vld), .issue_dst(issue_dst), .stall(stall), .busy_cnt(busy_cnt)
    );

    reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .RW(RW), .DA(DA), .D_DATA(D_DATA),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .issue_vld(issue_vld), .issue_dst(issue_dst), .stall(stall_nb), .busy_cnt(busy_cnt_nb)
    );

    // Reference model: plain arrays updated by the architectural rules.
    logic [31:0] m_reg  [32];
    bit          m_busy [32];

    function automatic logic [31:0] m_read(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && RW && (int'(DA) == a)) return D_DATA;
        return m_reg[a];
    endfunction

    function automatic bit m_rbusy(input int a, input bit byp);
        if (byp && RW && (int'(DA) == a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic bit m_stall(input bit byp);
        bit s = 1'b0;
        for (int k = 0; k < 2; k++)
            if (rd_en[k] && m_rbusy(int'(rd_addr[k*5 +: 5]), byp)) s = 1'b1;
        return s;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic m_update();
        if (RW && DA != 5'd0) m_reg[DA] = D_DATA;
        if (RW) m_busy[DA] = 1'b0;
        if (issue_vld && issue_dst != 5'd0) m_busy[issue_dst] = 1'b1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_ports(input string tag);
        for (int k = 0; k < 2; k++) begin
            int a = int'(rd_addr[k*5 +: 5]);
            chk({tag, "_data"},    rd_data[k*32 +: 32],    m_read(a, 1'b1));
            chk({tag, "_busy"},    32'(rd_busy[k]),        32'(m_rbusy(a, 1'b1)));
            chk({tag, "_data_nb"}, rd_data_nb[k*32 +: 32], m_read(a, 1'b0));
            chk({tag, "_busy_nb"}, 32'(rd_busy_nb[k]),     32'(m_rbusy(a, 1'b0)));
        end
        chk({tag, "_stall"},    32'(stall),    32'(m_stall(1'b1)));
        chk({tag, "_stall_nb"}, 32'(stall_nb), 32'(m_stall(1'b0)));
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
        chk("busy_cnt",    32'(busy_cnt),    32'(m_cnt()));
        chk("busy_cnt_nb", 32'(busy_cnt_nb), 32'(m_cnt()));
    endtask

    task automatic drive(input logic rw, input logic [4:0] da, input logic [31:0] dd,
                         input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en,
                         input logic iv, input logic [4:0] idst);
        RW = rw; DA = da; D_DATA = dd;
        rd_addr = {a1, a0}; rd_en = en;
        issue_vld = iv; issue_dst = idst;
        #1;
    endtask

    typedef struct {
        logic        rw;
        logic [4:0]  da;
        logic [31:0] dd;
        logic [4:0]  a0, a1;
        logic [1:0]  en;
        logic        iv;
        logic [4:0]  idst;
        logic [31:0] d0, d1;
        logic [1:0]  busy;
        logic        stl;
        logic [5:0]  cnt;
    } vec_t;

    vec_t tbl [6];

    initial begin
        // rw da   dd            a0  a1  en     iv  idst | d0        d1        busy   stl  cnt
        tbl[0] = '{1'b0, 5'd0,  32'h0,      5'd3,  5'd31, 2'b00, 1'b0, 5'd0,  32'd3,     32'd31,    2'b00, 1'b0, 6'd0};
        tbl[1] = '{1'b0, 5'd0,  32'h0,      5'd12, 5'd12, 2'b11, 1'b1, 5'd12, 32'd12,    32'd12,    2'b00, 1'b0, 6'd1};
        tbl[2] = '{1'b0, 5'd0,  32'h0,      5'd12, 5'd0,  2'b01, 1'b0, 5'd0,  32'd12,    32'd0,     2'b01, 1'b1, 6'd1};
        tbl[3] = '{1'b0, 5'd0,  32'h0,      5'd12, 5'd3,  2'b10, 1'b0, 5'd0,  32'd12,    32'd3,     2'b01, 1'b0, 6'd1};
        tbl[4] = '{1'b1, 5'd12, 32'hABCD,   5'd12, 5'd12, 2'b11, 1'b0, 5'd0,  32'hABCD,  32'hABCD,  2'b00, 1'b0, 6'd0};
        tbl[5] = '{1'b0, 5'd0,  32'h0,      5'd12, 5'd0,  2'b11, 1'b0, 5'd0,  32'hABCD,  32'd0,     2'b00, 1'b0, 6'd0};

        m_reset();
        rst = 1'b1;
        drive(1'b1, 5'd5, 32'hFFFF, 5'd5, 5'd0, 2'b11, 1'b1, 5'd5);
        chk("rst_bypass_data", rd_data[31:0], 32'h0);
        chk("rst_busy",        32'(rd_busy),  32'h0);
        chk("rst_stall",       32'(stall),    32'h0);
        repeat (2) @(posedge clk);
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd1, 2'b00, 1'b0, 5'd0);
        rst = 1'b0;
        #1;
        chk("rst_cnt",   32'(busy_cnt), 32'h0);
        chk("rst_data5", rd_data[31:0], 32'h0);

        // Test 1: fill reg i with i, then read everything back
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 2'b00, 1'b0, 5'd0);
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 2'b00, 1'b0, 5'd0);
            chk("fill_p0", rd_data[31:0],  (i == 0) ? 32'h0 : 32'(i));
            chk("fill_p1", rd_data[63:32], (i == 31) ? 32'h0 : 32'(31 - i));
        end

        for (int r = 0; r < 6; r++) begin
            drive(tbl[r].rw, tbl[r].da, tbl[r].dd, tbl[r].a0, tbl[r].a1, tbl[r].en, tbl[r].iv, tbl[r].idst);
            chk("tbl_d0",    rd_data[31:0],  tbl[r].d0);
            chk("tbl_d1",    rd_data[63:32], tbl[r].d1);
            chk("tbl_busy",  32'(rd_busy),   32'(tbl[r].busy));
            chk("tbl_stall", 32'(stall),     32'(tbl[r].stl));
            tick();
            chk("tbl_cnt",   32'(busy_cnt),  32'(tbl[r].cnt));
        end

        // Test 2: same-cycle write forwarded only with bypass
        drive(1'b1, 5'd7, 32'hDEADBEEF, 5'd7, 5'd0, 2'b00, 1'b0, 5'd0);
        chk("byp_data",   rd_data[31:0],    32'hDEADBEEF);
        chk("nobyp_data", rd_data_nb[31:0], 32'd7);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 2'b00, 1'b0, 5'd0);
        chk("post_wr_nb", rd_data_nb[63:32], 32'hDEADBEEF);

        // Test 3: issue 5, stall on read, clear by writeback
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0);
        chk("raw_busy",  32'(rd_busy[0]), 32'd1);
        chk("raw_stall", 32'(stall),      32'd1);
        chk("raw_cnt",   32'(busy_cnt),   32'd1);
        drive(1'b1, 5'd5, 32'h1234, 5'd5, 5'd0, 2'b01, 1'b0, 5'd0);
        chk("wb_busy",    32'(rd_busy[0]),    32'd0);
        chk("wb_stall",   32'(stall),         32'd0);
        chk("wb_busy_nb", 32'(rd_busy_nb[0]), 32'd1);
        tick();
        chk("wb_cnt", 32'(busy_cnt), 32'd0);

        // Test 4: set and clear of the same register in one cycle
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 2'b00, 1'b1, 5'd9);
        tick();
        drive(1'b1, 5'd9, 32'h99, 5'd9, 5'd0, 2'b00, 1'b1, 5'd9);
        tick();
        chk("setwin_cnt", 32'(busy_cnt), 32'd1);
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0);
        chk("setwin_busy", 32'(rd_busy[0]), 32'd1);
        chk("setwin_data", rd_data[31:0],   32'h99);
        drive(1'b1, 5'd9, 32'h9A, 5'd9, 5'd0, 2'b01, 1'b0, 5'd0);
        tick();
        chk("clr9_cnt", 32'(busy_cnt), 32'd0);

        // Test 5: register 0 is never written nor busy
        drive(1'b1, 5'd0, 32'd5, 5'd0, 5'd0, 2'b11, 1'b1, 5'd0);
        chk("zero_byp", rd_data[31:0], 32'h0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b11, 1'b0, 5'd0);
        chk("zero_cnt",  32'(busy_cnt),   32'd0);
        chk("zero_data", rd_data[63:32],  32'h0);
        chk("zero_busy", 32'(rd_busy),    32'd0);

        // Test 6: asynchronous reset mid-cycle
        drive(1'b1, 5'd3, 32'h55, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b00, 1'b1, 5'd4);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd4, 2'b11, 1'b0, 5'd0);
        chk("pre_rst_cnt",  32'(busy_cnt), 32'd2);
        chk("pre_rst_busy", 32'(rd_busy),  32'd3);
        chk("pre_rst_data", rd_data[31:0], 32'h55);
        rst = 1'b1;
        #1;
        chk("arst_cnt",   32'(busy_cnt),   32'd0);
        chk("arst_busy",  32'(rd_busy),    32'd0);
        chk("arst_data",  rd_data[31:0],   32'h0);
        chk("arst_stall", 32'(stall),      32'd0);
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post_rst_data", rd_data[31:0], 32'h0);
        chk("post_rst_busy", 32'(rd_busy),  32'd0);
        tick();

        // Randomized run; decode never issues while stalled
        for (int n = 0; n < 400; n++) begin
            logic [4:0] da;
            logic [4:0] a0, a1;
            da = 5'($urandom_range(0, 31));
            a0 = ($urandom_range(0, 3) == 0) ? da : 5'($urandom_range(0, 15));
            a1 = ($urandom_range(0, 3) == 0) ? da : 5'($urandom_range(0, 15));
            RW = 1'($urandom_range(0, 1)); DA = da; D_DATA = $urandom;
            rd_addr = {a1, a0}; rd_en = 2'($urandom_range(0, 3));
            issue_dst = 5'($urandom_range(0, 15));
            issue_vld = !m_stall(1'b1) && ($urandom_range(0, 2) != 0);
            #1;
            chk_ports("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
